// File: rtl/ram_march_tester_pkg.sv
// Shared types and constants for the RAM march tester.
// State encoding, phase codes and default geometry.
package ram_march_tester_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RMW_RD,
    S_RMW_WR,
    S_VER_RD,
    S_VER_CHK,
    S_DONE
  } state_e;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_FILL = 2'd1;
  localparam logic [1:0] PH_RMW  = 2'd2;
  localparam logic [1:0] PH_VER  = 2'd3;

  function automatic logic [1:0] phase_of(state_e s);
    logic [1:0] ph;
    ph = PH_IDLE;
    unique case (1'b1)
      (s == S_FILL):                     ph = PH_FILL;
      (s == S_RMW_RD || s == S_RMW_WR):  ph = PH_RMW;
      (s == S_VER_RD || s == S_VER_CHK): ph = PH_VER;
      default:                           ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/ram_march_tester_if.sv
// RAM port bundle between the march tester and the RAM.
// The tester is master; the RAM answers on rdata.
interface ram_march_tester_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              wren;

  modport master (
    output addr, wdata, wren,
    input  rdata
  );

  modport slave (
    input  addr, wdata, wren,
    output rdata
  );
endinterface

// File: rtl/march_addr_counter.sv
// Loadable up/down address counter for the march sequencer.
// Terminal flag marks the last address in the current direction.
module march_addr_counter #(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_val_i,
  input  logic              up_i,
  input  logic              en_i,
  output logic [ADDR_W-1:0] count_o,
  output logic              term_o
);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  // next count: load wins over stepping
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = up_i ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = up_i ? (count_q == {ADDR_W{1'b1}})
                        : (count_q == '0);

endmodule

// File: rtl/ram_march_tester.sv
// Three-phase march BIST sequencer for the 32 x 8 RAM.
// Reports pass/fail and the first failing address/data.
module ram_march_tester
  import ram_march_tester_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [DATA_W-1:0]  pattern,
  ram_march_tester_if.master ram,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ADDR_W-1:0]  fail_addr,
  output logic [DATA_W-1:0]  fail_data,
  output logic [1:0]         phase
);

  state_e            state_q;
  logic [DATA_W-1:0] p_q;
  logic              done_q;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [DATA_W-1:0] fail_data_q;

  logic              cnt_load;
  logic [ADDR_W-1:0] cnt_val;
  logic              cnt_up;
  logic              cnt_en;
  logic [ADDR_W-1:0] cnt;
  logic              cnt_term;

  logic rmw_ok;
  logic ver_ok;

  assign rmw_ok = (ram.rdata == p_q);
  assign ver_ok = (ram.rdata == ~p_q);

  march_addr_counter #(
    .ADDR_W(ADDR_W)
  ) u_cnt (
    .clk       (clock),
    .rst_n     (resetn),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .up_i      (cnt_up),
    .en_i      (cnt_en),
    .count_o   (cnt),
    .term_o    (cnt_term)
  );

  // address sequencing decoded from the current state
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_en   = 1'b0;
    cnt_up   = (state_q == S_FILL)
            || (state_q == S_RMW_RD)
            || (state_q == S_RMW_WR);
    unique case (1'b1)
      (state_q == S_IDLE || state_q == S_DONE): begin
        cnt_load = start;
      end
      (state_q == S_FILL): begin
        cnt_load = cnt_term;
        cnt_en   = !cnt_term;
      end
      (state_q == S_RMW_WR): begin
        cnt_load = rmw_ok && cnt_term;
        cnt_val  = {ADDR_W{1'b1}};
        cnt_en   = rmw_ok && !cnt_term;
      end
      (state_q == S_VER_CHK): begin
        cnt_en = ver_ok && !cnt_term;
      end
      default: begin
      end
    endcase
  end

  // march FSM with pattern and result capture
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      p_q         <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_FILL;
            p_q         <= pattern;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
          end
        end
        S_FILL: begin
          if (cnt_term) state_q <= S_RMW_RD;
        end
        S_RMW_RD: state_q <= S_RMW_WR;
        S_RMW_WR: begin
          if (!rmw_ok) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_addr_q <= cnt;
            fail_data_q <= ram.rdata;
          end else if (cnt_term) begin
            state_q <= S_VER_RD;
          end else begin
            state_q <= S_RMW_RD;
          end
        end
        S_VER_RD: state_q <= S_VER_CHK;
        S_VER_CHK: begin
          if (!ver_ok) begin
            state_q     <= S_DONE;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            fail_addr_q <= cnt;
            fail_data_q <= ram.rdata;
          end else if (cnt_term) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else begin
            state_q <= S_VER_RD;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // a failing compare must never write, so wren is gated live
  assign ram.wren  = (state_q == S_FILL)
                  || (state_q == S_RMW_WR && rmw_ok);
  assign ram.wdata = (state_q == S_FILL)   ? p_q
                   : (state_q == S_RMW_WR) ? ~p_q
                   : '0;
  assign ram.addr  = cnt;

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign phase     = phase_of(state_q);

endmodule

// File: tb/tb_ram_march_tester.sv
// Directed bench for ram_march_tester with a faultable RAM model.
// Covers pass, RMW/VERIFY stuck-at faults, reset and restart.
module tb_ram_march_tester;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [7:0] pattern;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] fail_addr;
  logic [7:0] fail_data;
  logic [1:0] phase;

  int n_chk;
  int n_fail;

  ram_march_tester_if ram ();

  ram_march_tester dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .pattern  (pattern),
    .ram      (ram),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .phase    (phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [7:0] mem [32];
  logic       f_en;
  logic [4:0] f_addr;
  logic [7:0] f_mask;
  int         n_wr_fa;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    ram.rdata = 8'h00;
    n_wr_fa   = 0;
  end

  // synchronous RAM model with an optional stuck-at-0 cell
  always @(posedge clock) begin
    if (ram.wren) begin
      if (f_en && ram.addr == f_addr) begin
        mem[ram.addr] <= ram.wdata & ~f_mask;
        n_wr_fa       <= n_wr_fa + 1;
      end else begin
        mem[ram.addr] <= ram.wdata;
      end
    end
    ram.rdata <= mem[ram.addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_all();
    return {7'd0, ram.addr, ram.wdata, ram.wren,
            busy, done, pass, fail_addr, fail_data,
            phase};
  endfunction

  // one run: start edge k, then count busy cycles
  task automatic run(input  logic [7:0] pat,
                     input  bit         toggle,
                     input  bit         hold,
                     output int         cyc,
                     output logic [1:0] last_ph);
    @(negedge clock);
    pattern = pat;
    start   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    if (!hold) start = 1'b0;
    cyc     = 0;
    last_ph = 2'd0;
    while (busy && cyc < 400) begin
      cyc++;
      last_ph = phase;
      if (toggle) begin
        pattern = ~pattern;
        start   = (cyc == 20);
      end
      @(negedge clock);
    end
    if (toggle) start = 1'b0;
  endtask

  function automatic int bad_words(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      if (mem[i] !== v) n++;
    return n;
  endfunction

  int         cyc;
  logic [1:0] lph;
  int         base;

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    start   = 1'b0;
    pattern = 8'h00;
    f_en    = 1'b0;
    f_addr  = 5'h00;
    f_mask  = 8'h00;
    #1;
    chk("reset_outs", outs_all(), 32'd0);
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("idle_outs", outs_all(), 32'd0);

    // fault-free run, pattern 0x55
    run(8'h55, 1'b0, 1'b0, cyc, lph);
    chk("t1_busy_cyc", cyc, 160);
    chk("t1_done", done, 1);
    chk("t1_pass", pass, 1);
    chk("t1_phase", phase, 0);
    chk("t1_last_ph", lph, 3);
    for (int i = 0; i < 32; i++)
      chk($sformatf("t1_mem%0d", i), mem[i], 8'hAA);

    // 0x0C bit3 stuck-at-0, fails in RMW
    f_en   = 1'b1;
    f_addr = 5'h0C;
    f_mask = 8'h08;
    base   = n_wr_fa;
    run(8'h0F, 1'b0, 1'b0, cyc, lph);
    chk("t2_busy_cyc", cyc, 58);
    chk("t2_last_ph", lph, 2);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 0);
    chk("t2_fail_addr", fail_addr, 5'h0C);
    chk("t2_fail_data", fail_data, 8'h07);
    chk("t2_writes_0c", n_wr_fa - base, 1);
    chk("t2_mem0c", mem[12], 8'h07);
    chk("t2_mem0b", mem[11], 8'hF0);

    // 0x1F bit7 stuck-at-0, fails on first VERIFY read
    f_addr = 5'h1F;
    f_mask = 8'h80;
    run(8'h00, 1'b0, 1'b0, cyc, lph);
    chk("t3_busy_cyc", cyc, 98);
    chk("t3_last_ph", lph, 3);
    chk("t3_pass", pass, 0);
    chk("t3_fail_addr", fail_addr, 5'h1F);
    chk("t3_fail_data", fail_data, 8'h7F);
    f_en = 1'b0;

    // asynchronous reset during an RMW write cycle
    @(negedge clock);
    pattern = 8'h5A;
    start   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 51; i++) @(negedge clock);
    chk("t4_wren_pre", ram.wren, 1);
    chk("t4_phase_pre", phase, 2);
    #2 resetn = 1'b0;
    #1;
    chk("t4_reset_outs", outs_all(), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    run(8'h3C, 1'b0, 1'b0, cyc, lph);
    chk("t4_busy_cyc", cyc, 160);
    chk("t4_pass", pass, 1);
    chk("t4_bad_words", bad_words(8'hC3), 0);

    // start pulse and pattern churn while busy
    run(8'hC3, 1'b1, 1'b0, cyc, lph);
    chk("t5_busy_cyc", cyc, 160);
    chk("t5_pass", pass, 1);
    chk("t5_bad_words", bad_words(8'h3C), 0);

    // start held high through done restarts
    run(8'h81, 1'b0, 1'b1, cyc, lph);
    chk("t6_busy_cyc", cyc, 160);
    chk("t6_done", done, 1);
    chk("t6_pass", pass, 1);
    @(negedge clock);
    start = 1'b0;
    chk("t6_re_busy", busy, 1);
    chk("t6_re_done", done, 0);
    chk("t6_re_pass", pass, 0);
    chk("t6_re_phase", phase, 1);
    cyc = 1;
    while (busy && cyc < 400) begin
      @(negedge clock);
      if (busy) cyc++;
    end
    chk("t6_re_cyc", cyc, 160);
    chk("t6_re_final", {done, pass}, 2'b11);
    chk("t6_bad_words", bad_words(8'h7E), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             n_chk, n_fail);
    $finish;
  end

endmodule
